// File: rtl/i2s_adc_rx.sv
// I2S capture receiver: oversampled bclk/lrclk/sdata, MSB-first stereo deserialiser, frame FIFO.
// Optional peak meter on level_o when I2S_RX_LEVEL_EN is defined.
module i2s_adc_rx #(
    parameter int unsigned SAMPLE_W    = 16,
    parameter int unsigned FIFO_DEPTH  = 4,
    parameter int unsigned SYNC_STAGES = 2,
    parameter int unsigned LEVEL_DECAY = 8
) (
    input  logic                clk_i,
    input  logic                rst_ni,
    input  logic                enable_i,
    input  logic                bclk_i,
    input  logic                lrclk_i,
    input  logic                sdata_i,
    output logic [SAMPLE_W-1:0] left_o,
    output logic [SAMPLE_W-1:0] right_o,
    output logic                valid_o,
    input  logic                ready_i,
    output logic                overflow_o,
    output logic                frame_err_o,
    output logic [SAMPLE_W-2:0] level_o
);
    localparam int unsigned CntW = $clog2(SAMPLE_W + 1);
    localparam int unsigned PtrW = $clog2(FIFO_DEPTH);
    localparam logic [CntW-1:0] FullCnt = CntW'(SAMPLE_W);
    localparam logic [PtrW:0] DepthCnt = (PtrW + 1)'(FIFO_DEPTH);

    typedef enum logic [1:0] {StIdle, StWaitLeft, StLeft, StRight} state_e;

    logic [SYNC_STAGES-1:0] r_bclk_sync, r_lr_sync, r_sd_sync;
    logic                   r_bclk_prev;
    logic                   w_bclk_s, w_lr, w_sd, w_bclk_rise, w_boundary;

    logic [CntW-1:0]     r_bit_cnt;
    logic [SAMPLE_W-1:0] r_shift, r_left, w_right_word;
    logic                r_lr_last, w_cnt_full;
    state_e              r_state, w_state_next;
    logic                w_latch_left, w_push, w_slot_err, r_frame_err;

    logic [SAMPLE_W-1:0] r_mem_l [FIFO_DEPTH];
    logic [SAMPLE_W-1:0] r_mem_r [FIFO_DEPTH];
    logic [PtrW-1:0]     r_wptr, r_rptr;
    logic [PtrW:0]       r_count;
    logic                r_overflow, w_full, w_pop, w_push_ok;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_bclk_sync <= '0;
            r_lr_sync   <= '0;
            r_sd_sync   <= '0;
            r_bclk_prev <= 1'b0;
        end else begin
            r_bclk_sync <= (r_bclk_sync << 1) | SYNC_STAGES'(bclk_i);
            r_lr_sync   <= (r_lr_sync << 1) | SYNC_STAGES'(lrclk_i);
            r_sd_sync   <= (r_sd_sync << 1) | SYNC_STAGES'(sdata_i);
            r_bclk_prev <= w_bclk_s;
        end
    end

    assign w_bclk_s     = r_bclk_sync[SYNC_STAGES-1];
    assign w_lr         = r_lr_sync[SYNC_STAGES-1];
    assign w_sd         = r_sd_sync[SYNC_STAGES-1];
    assign w_bclk_rise  = w_bclk_s & ~r_bclk_prev;
    assign w_boundary   = w_bclk_rise & (w_lr != r_lr_last);
    assign w_cnt_full   = (r_bit_cnt == FullCnt);
    assign w_right_word = {r_shift[SAMPLE_W-2:0], w_sd};

    // The bit sampled on an lrclk change belongs to the previous slot and is dropped.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_bit_cnt <= '0;
            r_shift   <= '0;
            r_left    <= '0;
            r_lr_last <= 1'b0;
        end else if (!enable_i) begin
            r_bit_cnt <= '0;
            r_shift   <= '0;
            r_left    <= '0;
            r_lr_last <= 1'b0;
        end else if (w_bclk_rise) begin
            r_lr_last <= w_lr;
            if (w_lr != r_lr_last) begin
                r_bit_cnt <= '0;
            end else if (!w_cnt_full) begin
                r_shift   <= w_right_word;
                r_bit_cnt <= r_bit_cnt + CntW'(1);
            end
            if (w_latch_left) begin
                r_left <= r_shift;
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state <= StIdle;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        if (!enable_i) begin
            w_state_next = StIdle;
        end else begin
            unique case (r_state)
                StIdle:     w_state_next = StWaitLeft;
                StWaitLeft: if (w_boundary && !w_lr) w_state_next = StLeft;
                StLeft:     if (w_boundary) w_state_next = w_cnt_full ? StRight : StWaitLeft;
                StRight:    if (w_boundary) w_state_next = StLeft;
                default:    w_state_next = StIdle;
            endcase
        end
    end

    always_comb begin
        w_latch_left = 1'b0;
        w_push       = 1'b0;
        w_slot_err   = 1'b0;
        if (enable_i) begin
            unique case (r_state)
                StLeft: begin
                    if (w_boundary) begin
                        w_latch_left = w_cnt_full;
                        w_slot_err   = !w_cnt_full;
                    end
                end
                StRight: begin
                    if (w_boundary) begin
                        w_slot_err = !w_cnt_full;
                    end else if (w_bclk_rise && r_bit_cnt == FullCnt - CntW'(1)) begin
                        w_push = 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_frame_err <= 1'b0;
        end else begin
            r_frame_err <= w_slot_err;
        end
    end

    assign w_full    = (r_count == DepthCnt);
    assign w_pop     = valid_o & ready_i;
    assign w_push_ok = w_push & (!w_full | w_pop);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_wptr     <= '0;
            r_rptr     <= '0;
            r_count    <= '0;
            r_overflow <= 1'b0;
        end else if (!enable_i) begin
            r_wptr     <= '0;
            r_rptr     <= '0;
            r_count    <= '0;
            r_overflow <= 1'b0;
        end else begin
            if (w_push_ok) r_wptr <= r_wptr + PtrW'(1);
            if (w_pop) r_rptr <= r_rptr + PtrW'(1);
            if (w_push_ok && !w_pop) begin
                r_count <= r_count + (PtrW + 1)'(1);
            end else if (!w_push_ok && w_pop) begin
                r_count <= r_count - (PtrW + 1)'(1);
            end
            if (w_push && w_full && !w_pop) r_overflow <= 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (w_push_ok) begin
            r_mem_l[r_wptr] <= r_left;
            r_mem_r[r_wptr] <= w_right_word;
        end
    end

    // Head is forced to zero while empty so stale or unwritten entries never show.
    assign valid_o     = (r_count != '0);
    assign left_o      = valid_o ? r_mem_l[r_rptr] : '0;
    assign right_o     = valid_o ? r_mem_r[r_rptr] : '0;
    assign overflow_o  = r_overflow;
    assign frame_err_o = r_frame_err;

`ifdef I2S_RX_LEVEL_EN
    logic [SAMPLE_W-2:0] r_level, w_mag_l, w_mag_r, w_mag;

    // Only the most negative code stays negative after negation; it saturates.
    function automatic logic [SAMPLE_W-2:0] f_mag(input logic [SAMPLE_W-1:0] x);
        logic [SAMPLE_W-1:0] neg;
        neg = ~x + 1'b1;
        if (!x[SAMPLE_W-1]) begin
            f_mag = x[SAMPLE_W-2:0];
        end else if (neg[SAMPLE_W-1]) begin
            f_mag = '1;
        end else begin
            f_mag = neg[SAMPLE_W-2:0];
        end
    endfunction

    assign w_mag_l = f_mag(r_left);
    assign w_mag_r = f_mag(w_right_word);
    assign w_mag   = (w_mag_l > w_mag_r) ? w_mag_l : w_mag_r;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_level <= '0;
        end else if (!enable_i) begin
            r_level <= '0;
        end else if (w_push_ok) begin
            r_level <= (w_mag > r_level) ? w_mag : r_level - (r_level >> LEVEL_DECAY);
        end
    end

    assign level_o = r_level;
`else
    assign level_o = '0;
`endif

endmodule

// File: tb/tb_i2s_adc_rx.sv
// Self-checking bench for i2s_adc_rx: frame queue model plus per-cycle head/latency compare.
module tb_i2s_adc_rx;
    localparam int SW    = 16;
    localparam int DEPTH = 4;
    localparam int SYNC  = 2;
    localparam int LAT   = SYNC + 2;
    localparam int SLOT  = 32;

    logic        clk_i = 1'b0;
    logic        rst_ni = 1'b0;
    logic        enable_i = 1'b0;
    logic        bclk_i = 1'b0;
    logic        lrclk_i = 1'b0;
    logic        sdata_i = 1'b0;
    logic        ready_i = 1'b0;
    logic [15:0] left_o, right_o;
    logic        valid_o, overflow_o, frame_err_o;
    logic [14:0] level_o;

    always #5 clk_i = ~clk_i;

    i2s_adc_rx #(
        .SAMPLE_W   (SW),
        .FIFO_DEPTH (DEPTH),
        .SYNC_STAGES(SYNC),
        .LEVEL_DECAY(8)
    ) dut (
        .clk_i      (clk_i),
        .rst_ni     (rst_ni),
        .enable_i   (enable_i),
        .bclk_i     (bclk_i),
        .lrclk_i    (lrclk_i),
        .sdata_i    (sdata_i),
        .left_o     (left_o),
        .right_o    (right_o),
        .valid_o    (valid_o),
        .ready_i    (ready_i),
        .overflow_o (overflow_o),
        .frame_err_o(frame_err_o),
        .level_o    (level_o)
    );

    int          vectors = 0;
    int          miscompares = 0;
    int          err_seen = 0;
    int          exp_err = 0;
    int          pops = 0;
    int          exp_pops = 0;
    int unsigned cyc = 0;
    logic [31:0] q[$];
    int unsigned qc[$];
    logic        exp_ovf = 1'b0;
    int          exp_lvl = 0;
    logic [15:0] cur_l, cur_r;
    bit          cur_exp = 1'b0;

    always @(posedge clk_i) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic int mag(input logic signed [15:0] x);
        int v;
        v = int'(x);
        if (v < 0) v = -v;
        if (v > 32767) v = 32767;
        return v;
    endfunction

    // A completed frame enters the model FIFO unless it is already full.
    task automatic model_push(input logic [15:0] l, input logic [15:0] r);
        int m;
        if (q.size() == DEPTH) begin
            exp_ovf = 1'b1;
        end else begin
            q.push_back({l, r});
            qc.push_back(cyc);
            m = (mag(l) > mag(r)) ? mag(l) : mag(r);
            exp_lvl = (m > exp_lvl) ? m : exp_lvl - (exp_lvl >> 8);
        end
    endtask

    task automatic model_clear();
        q.delete();
        qc.delete();
        exp_ovf = 1'b0;
        exp_lvl = 0;
    endtask

    // Per-cycle compare: head must match model front; a queued frame must appear within LAT.
    always @(negedge clk_i) begin
        if (rst_ni) begin
            if (frame_err_o) err_seen++;
            if (valid_o) begin
                if (q.size() == 0) begin
                    check("valid_with_empty_model", {63'b0, valid_o}, 64'd0);
                end else begin
                    check("head_frame", {32'b0, left_o, right_o}, {32'b0, q[0]});
                    if (ready_i) begin
                        void'(q.pop_front());
                        void'(qc.pop_front());
                        pops++;
                    end
                end
            end else if (q.size() != 0 && cyc - qc[0] > LAT) begin
                check("valid_latency", {63'b0, valid_o}, 64'd1);
            end
        end
    end

    task automatic drive_bit(input logic lr, input logic d, input bit push);
        bclk_i  = 1'b0;
        lrclk_i = lr;
        sdata_i = d;
        repeat (4) @(posedge clk_i);
        #1;
        bclk_i = 1'b1;
        if (push) model_push(cur_l, cur_r);
        repeat (4) @(posedge clk_i);
        #1;
    endtask

    // Slot bit 0 is the I2S delay bit; bits 1..SW carry the word; padding is all ones.
    task automatic send_bits(input logic lr, input logic [15:0] w, input int from, input int to);
        for (int i = from; i < to; i++) begin
            logic d;
            d = (i >= 1 && i <= SW) ? w[SW-i] : 1'b1;
            drive_bit(lr, d, cur_exp && lr && (i == SW));
        end
    endtask

    task automatic send_frame(input logic [15:0] l, input logic [15:0] r,
                              input int lbits, input int rbits, input bit exp);
        cur_l   = l;
        cur_r   = r;
        cur_exp = exp;
        send_bits(1'b0, l, 0, lbits);
        send_bits(1'b1, r, 0, rbits);
    endtask

    task automatic checkpoint(input string tag);
        check({tag, "_overflow"}, {63'b0, overflow_o}, {63'b0, exp_ovf});
        check({tag, "_frame_err_count"}, 64'(err_seen), 64'(exp_err));
        check({tag, "_pops"}, 64'(pops), 64'(exp_pops));
`ifdef I2S_RX_LEVEL_EN
        check({tag, "_level"}, {49'b0, level_o}, 64'(exp_lvl));
`else
        check({tag, "_level"}, {49'b0, level_o}, 64'd0);
`endif
    endtask

    task automatic set_enable(input logic en);
        enable_i = en;
        @(posedge clk_i);
        #1;
        if (!en) model_clear();
    endtask

    task automatic check_idle_outputs(input string tag);
        check({tag, "_valid"}, {63'b0, valid_o}, 64'd0);
        check({tag, "_left"}, {48'b0, left_o}, 64'd0);
        check({tag, "_right"}, {48'b0, right_o}, 64'd0);
        check({tag, "_overflow0"}, {63'b0, overflow_o}, 64'd0);
        check({tag, "_frame_err0"}, {63'b0, frame_err_o}, 64'd0);
        check({tag, "_level0"}, {49'b0, level_o}, 64'd0);
    endtask

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        repeat (2) @(posedge clk_i);
        #1;
        check_idle_outputs("reset");
        rst_ni = 1'b1;
        repeat (2) @(posedge clk_i);
        #1;

        // Basic capture, head held with ready low, literal values.
        set_enable(1'b1);
        cur_exp = 1'b0;
        send_bits(1'b1, 16'h0000, 0, SLOT);
        send_frame(16'h8001, 16'h7FFE, SLOT, SLOT, 1'b1);
        check("t1_valid", {63'b0, valid_o}, 64'd1);
        check("t1_left", {48'b0, left_o}, 64'h8001);
        check("t1_right", {48'b0, right_o}, 64'h7FFE);
        ready_i = 1'b1;
        exp_pops += 1;
        repeat (3) @(posedge clk_i);
        #1;
        check("t1_drained", {63'b0, valid_o}, 64'd0);
        checkpoint("t1");

        send_frame(16'h1234, 16'h5678, SLOT, SLOT, 1'b1);
        send_frame(16'hFFFF, 16'h0000, SLOT, SLOT, 1'b1);
        send_frame(16'h0001, 16'h8000, SLOT, SLOT, 1'b1);
        send_frame(16'hA5A5, 16'h5A5A, SLOT, SLOT, 1'b1);
        exp_pops += 4;
        checkpoint("t2");

        // Overflow: six frames into a four-deep FIFO with no consumer.
        ready_i = 1'b0;
        for (int i = 1; i <= 6; i++) begin
            send_frame(16'h1000 | 16'(i), 16'hE000 | 16'(i), SLOT, SLOT, 1'b1);
            if (i == 4) checkpoint("t3_after4");
            if (i == 5) checkpoint("t3_after5");
        end
        check("t3_head_left", {48'b0, left_o}, 64'h1001);
        check("t3_head_right", {48'b0, right_o}, 64'hE001);
        ready_i = 1'b1;
        exp_pops += 4;
        repeat (10) @(posedge clk_i);
        #1;
        check("t3_drained", {63'b0, valid_o}, 64'd0);
        checkpoint("t3_end");

        // Disable mid-slot, re-enable mid right slot: only the next full pair is captured.
        set_enable(1'b0);
        check("t4_flush_valid", {63'b0, valid_o}, 64'd0);
        check("t4_flush_ovf", {63'b0, overflow_o}, 64'd0);
        cur_exp = 1'b0;
        send_bits(1'b0, 16'h1111, 0, SLOT);
        send_bits(1'b1, 16'h2222, 0, 8);
        enable_i = 1'b1;
        send_bits(1'b1, 16'h2222, 8, SLOT);
        send_frame(16'h3333, 16'h4444, SLOT, SLOT, 1'b1);
        send_frame(16'h5555, 16'h6666, SLOT, SLOT, 1'b1);
        exp_pops += 2;
        checkpoint("t4");

        // Short left slot, then short right slot; each errors once and resyncs.
        send_frame(16'h7777, 16'h8888, 10, SLOT, 1'b0);
        exp_err += 1;
        send_frame(16'h9999, 16'hAAAA, SLOT, SLOT, 1'b1);
        exp_pops += 1;
        checkpoint("t5_left_short");
        send_frame(16'hBBBB, 16'hCCCC, SLOT, 10, 1'b0);
        exp_err += 1;
        send_frame(16'h0F0F, 16'hF0F0, SLOT, SLOT, 1'b1);
        exp_pops += 1;
        checkpoint("t5_right_short");

        // Async reset mid-word with a frame waiting.
        ready_i = 1'b0;
        send_frame(16'hDDDD, 16'hEEEE, SLOT, SLOT, 1'b1);
        check("t6_valid_before", {63'b0, valid_o}, 64'd1);
        cur_exp = 1'b0;
        send_bits(1'b0, 16'h1357, 0, 6);
        rst_ni = 1'b0;
        #1;
        check_idle_outputs("t6_reset");
        model_clear();
        @(posedge clk_i);
        #1;
        rst_ni = 1'b1;
        send_bits(1'b0, 16'h1357, 6, SLOT);
        send_bits(1'b1, 16'h9BDF, 0, SLOT);
        ready_i = 1'b1;
        send_frame(16'h2468, 16'hACE0, SLOT, SLOT, 1'b1);
        exp_pops += 1;
        checkpoint("t6");

`ifdef I2S_RX_LEVEL_EN
        set_enable(1'b0);
        set_enable(1'b1);
        cur_exp = 1'b0;
        send_bits(1'b1, 16'h0000, 0, SLOT);
        send_frame(16'h8000, 16'h0000, SLOT, SLOT, 1'b1);
        check("t7_level_peak", {49'b0, level_o}, 64'd32767);
        send_frame(16'h0000, 16'h0000, SLOT, SLOT, 1'b1);
        check("t7_level_decay1", {49'b0, level_o}, 64'd32640);
        for (int i = 0; i < 19; i++) begin
            send_frame(16'h0000, 16'h0000, SLOT, SLOT, 1'b1);
        end
        exp_pops += 21;
        checkpoint("t7");
`endif

        repeat (4) @(posedge clk_i);
        #1;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
